// File: rtl/bit_clmul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle carry-less multiply unit between two issue pipes.
// Optional one-entry result cache enabled by defining BIT_CLMUL_CACHE_EN.
module bit_clmul_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    input  logic [OPW-1:0]  req_op0,
    input  logic [OPW-1:0]  req_op1,
    input  logic [XLEN-1:0] req_rs1_0,
    input  logic [XLEN-1:0] req_rs1_1,
    input  logic [XLEN-1:0] req_rs2_0,
    input  logic [XLEN-1:0] req_rs2_1,
    output logic [1:0]      req_ack,
    input  logic [1:0]      kill,
    output logic [1:0]      resp_valid,
    output logic [XLEN-1:0] resp_result,
    output logic            busy,
    output logic            clmul_enable,
    output logic [OPW-1:0]  clmul_op,
    output logic [XLEN-1:0] clmul_rdata1,
    output logic [XLEN-1:0] clmul_rdata2,
    input  logic [XLEN-1:0] clmul_result,
    input  logic            clmul_ready,
    output logic [1:0]      debug_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            prio;
    logic            owner;
    logic            killed;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] result_q;

    logic [1:0]      cand;
    logic            grant_valid;
    logic            grant;
    logic [OPW-1:0]  sel_op;
    logic [XLEN-1:0] sel_rs1;
    logic [XLEN-1:0] sel_rs2;
    logic            cache_hit;

    assign cand[0]     = req_valid[0] & ~kill[0] & (|req_op0);
    assign cand[1]     = req_valid[1] & ~kill[1] & (|req_op1);
    assign grant_valid = |cand;
    assign grant       = (&cand) ? prio : cand[1];
    assign sel_op      = grant ? req_op1   : req_op0;
    assign sel_rs1     = grant ? req_rs1_1 : req_rs1_0;
    assign sel_rs2     = grant ? req_rs2_1 : req_rs2_0;

`ifdef BIT_CLMUL_CACHE_EN
    logic            cache_valid;
    logic [OPW-1:0]  cache_op;
    logic [XLEN-1:0] cache_rs1;
    logic [XLEN-1:0] cache_rs2;
    logic [XLEN-1:0] cache_result;

    assign cache_hit = cache_valid && (cache_op == sel_op) &&
                       (cache_rs1 == sel_rs1) && (cache_rs2 == sel_rs2);

    // Written on every unit completion, killed ops included, since the result is still correct.
    always_ff @(posedge clock) begin
        if (reset) begin
            cache_valid  <= 1'b0;
            cache_op     <= '0;
            cache_rs1    <= '0;
            cache_rs2    <= '0;
            cache_result <= '0;
        end else if (state == WAIT && clmul_ready) begin
            cache_valid  <= 1'b1;
            cache_op     <= op_q;
            cache_rs1    <= rs1_q;
            cache_rs2    <= rs2_q;
            cache_result <= clmul_result;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        req_ack     = 2'b00;
        resp_valid  = 2'b00;
        resp_result = '0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ack[grant] = 1'b1;
                    state_next     = cache_hit ? DONE : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (clmul_ready) state_next = DONE;
            end
            DONE: begin
                if (!killed) begin
                    resp_valid[owner] = 1'b1;
                    resp_result       = result_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            killed   <= 1'b0;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant;
                        op_q   <= sel_op;
                        rs1_q  <= sel_rs1;
                        rs2_q  <= sel_rs2;
                        killed <= 1'b0;
`ifdef BIT_CLMUL_CACHE_EN
                        if (cache_hit) result_q <= cache_result;
`endif
                    end
                end
                WAIT: begin
                    // A kill coinciding with the ready pulse still suppresses the response.
                    if (kill[owner]) killed <= 1'b1;
                    if (clmul_ready) result_q <= clmul_result;
                end
                DONE: prio <= ~owner;
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign clmul_enable = (state == ISSUE);
    assign clmul_op     = op_q;
    assign clmul_rdata1 = rs1_q;
    assign clmul_rdata2 = rs2_q;
    assign debug_state  = state;

endmodule

// File: tb/tb_bit_clmul_arbiter.sv
// Self-checking bench for bit_clmul_arbiter: behavioural clmul unit, expected-result queue, directed and random stimulus.
// Handshake: req_valid is held until the cycle req_ack is seen; the unit samples on clmul_enable and pulses clmul_ready once.
module tb_bit_clmul_arbiter;
    localparam int XLEN = 32;
    localparam int OPW  = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [OPW-1:0]  req_op0 = '0, req_op1 = '0;
    logic [XLEN-1:0] req_rs1_0 = '0, req_rs1_1 = '0, req_rs2_0 = '0, req_rs2_1 = '0;
    logic [1:0]      req_ack;
    logic [1:0]      kill = 2'b00;
    logic [1:0]      resp_valid;
    logic [XLEN-1:0] resp_result;
    logic            busy;
    logic            clmul_enable;
    logic [OPW-1:0]  clmul_op;
    logic [XLEN-1:0] clmul_rdata1, clmul_rdata2;
    logic [XLEN-1:0] clmul_result = '0;
    logic            clmul_ready = 1'b0;
    logic [1:0]      debug_state;

    bit_clmul_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
        .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
        .req_ack(req_ack), .kill(kill), .resp_valid(resp_valid), .resp_result(resp_result),
        .busy(busy), .clmul_enable(clmul_enable), .clmul_op(clmul_op),
        .clmul_rdata1(clmul_rdata1), .clmul_rdata2(clmul_rdata2),
        .clmul_result(clmul_result), .clmul_ready(clmul_ready), .debug_state(debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [XLEN-1:0] clmul_ref(input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = '0;
        for (int i = 0; i < XLEN; i++)
            if (b[i]) p = p ^ ({{XLEN{1'b0}}, a} << i);
        case (op)
            3'b001:  return p[XLEN-1:0];
            3'b010:  return p[2*XLEN-1:XLEN];
            3'b100:  return p[2*XLEN-2:XLEN-1];
            default: return '0;
        endcase
    endfunction

    // ---------------- behavioural shared unit ----------------
    int              unit_lat = 0;
    logic            u_busy = 1'b0;
    int              u_cnt = 0;
    logic [XLEN-1:0] u_res = '0;
    logic [OPW-1:0]  u_op = '0;
    logic [XLEN-1:0] u_a = '0, u_b = '0;

    always @(posedge clock) begin
        clmul_ready <= 1'b0;
        if (reset) begin
            u_busy <= 1'b0;
            u_cnt  <= 0;
        end else if (u_busy) begin
            if (u_cnt == 0) begin
                clmul_ready  <= 1'b1;
                clmul_result <= u_res;
                u_busy       <= 1'b0;
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end else if (clmul_enable) begin
            u_busy <= 1'b1;
            u_cnt  <= unit_lat;
            u_op   <= clmul_op;
            u_a    <= clmul_rdata1;
            u_b    <= clmul_rdata2;
            u_res  <= clmul_ref(clmul_op, clmul_rdata1, clmul_rdata2);
        end
    end

    // ---------------- scoreboard ----------------
    // entry = {cached, pipe, result}
    logic [XLEN+1:0] exp_q[$];
    int grant_pipe_q[$];
    int grant_gap_q[$];

    logic            c_valid = 1'b0;
    logic [OPW-1:0]  c_op = '0;
    logic [XLEN-1:0] c_a = '0, c_b = '0;

    int   ack_cyc = 0, ready_cyc = 0, done_cyc = 0;
    int   en_cnt = 0, ack_en_cnt = 0;
    logic prev_en = 1'b0;

    always @(negedge clock) begin
        logic [XLEN+1:0] e;
        if (reset) begin
            c_valid = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (|req_ack) begin
                check("ack_onehot", 64'($countones(req_ack)), 1);
                check("ack_while_busy", busy, 0);
                ack_cyc    = cyc;
                ack_en_cnt = en_cnt;
                grant_pipe_q.push_back(req_ack[1] ? 1 : 0);
                grant_gap_q.push_back(cyc - done_cyc);
            end
            if (clmul_enable) begin
                check("enable_latency", cyc, ack_cyc + 1);
                check("enable_pulse", prev_en, 0);
                check("enable_unit_idle", u_busy, 0);
                en_cnt++;
            end
            prev_en = clmul_enable;
            if (clmul_ready) begin
                ready_cyc = cyc;
                done_cyc  = cyc + 1;
                c_valid   = 1'b1;
                c_op      = u_op;
                c_a       = u_a;
                c_b       = u_b;
            end
            if (|resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", resp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_pipe", resp_valid, e[XLEN] ? 2'b10 : 2'b01);
                    check("resp_result", resp_result, e[XLEN-1:0]);
                    if (e[XLEN+1]) begin
                        done_cyc = cyc;
                        check("cache_latency", cyc, ack_cyc + 1);
                        check("cache_no_enable", en_cnt, ack_en_cnt);
                    end else begin
                        check("resp_latency", cyc, ready_cyc + 1);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int p, input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input bit expect_resp);
        bit acked = 0;
        bit cached = 0;
        if (p == 0) begin req_op0 = op; req_rs1_0 = a; req_rs2_0 = b; end
        else        begin req_op1 = op; req_rs1_1 = a; req_rs2_1 = b; end
        req_valid[p] = 1'b1;
        for (int i = 0; i < 60 && !acked; i++) begin
            @(negedge clock);
            if (req_ack[p]) acked = 1;
        end
        if (!acked) begin
            check("ack_timeout", 0, 1);
        end else if (expect_resp) begin
`ifdef BIT_CLMUL_CACHE_EN
            cached = c_valid && c_op == op && c_a == a && c_b == b;
`endif
            exp_q.push_back({cached, p[0], exp_res});
        end
        @(posedge clock); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        bit idle = 0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0) idle = 1;
        end
        if (!idle) check("drain_timeout", 1, 0);
        @(posedge clock); #1;
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 32'h3;
            1:       return 32'h5;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ack"}, req_ack, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_result"}, resp_result, 0);
        check({tag, "_enable"}, clmul_enable, 0);
        check({tag, "_op"}, clmul_op, 0);
        check({tag, "_rdata1"}, clmul_rdata1, 0);
        check({tag, "_rdata2"}, clmul_rdata2, 0);
        check({tag, "_state"}, debug_state, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] a, b, a2, b2;
        int              mode;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // basic clmul on pipe 0, then cache-hit candidate and miss
        unit_lat = 1;
        drive_req(0, 3'b001, 32'h3, 32'h3, 32'h5, 1);
        drain();
        drive_req(0, 3'b001, 32'h3, 32'h3, 32'h5, 1);
        drain();
        drive_req(0, 3'b001, 32'h3, 32'h5, 32'hF, 1);
        drain();

        // clmulh / clmulr on pipe 1
        unit_lat = 2;
        drive_req(1, 3'b010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        drain();
        drive_req(1, 3'b100, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1);
        drain();

        // kill held through WAIT, pipe 1 waiting behind
        unit_lat = 3;
        drive_req(0, 3'b001, 32'h1234, 32'h77, 32'h0, 0);
        kill[0] = 1'b1;
        drive_req(1, 3'b001, 32'h6, 32'h3, 32'hA, 1);
        check("kill_hold_next_grant_gap", grant_gap_q[$], 1);
        kill[0] = 1'b0;
        drain();

        // kill only in the clmul_ready cycle
        unit_lat = 2;
        drive_req(0, 3'b001, 32'h4321, 32'h99, 32'h0, 0);
        fork
            begin
                repeat (4) @(posedge clock); #1;
                kill[0] = 1'b1;
                @(posedge clock); #1;
                kill[0] = 1'b0;
            end
            drive_req(1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1);
        join
        check("kill_ready_next_grant_gap", grant_gap_q[$], 1);
        drain();

        // kill while idle blocks the grant
        kill[1] = 1'b1;
        fork
            drive_req(1, 3'b001, 32'h7, 32'h7, 32'h15, 1);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    check("idle_kill_no_ack", req_ack, 0);
                end
                @(posedge clock); #1;
                kill[1] = 1'b0;
            end
        join
        drain();

        // reset during WAIT
        unit_lat = 8;
        drive_req(0, 3'b001, 32'hABCD, 32'h11, 32'h0, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("mid_reset");
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("post_reset_no_resp", resp_valid, 0);
        end
        @(posedge clock); #1;

        // dual requests from reset alternate 0,1,0,1
        unit_lat = 1;
        grant_pipe_q.delete();
        grant_gap_q.delete();
        fork
            begin
                for (int k = 0; k < 3; k++)
                    drive_req(0, 3'b001, 32'h100 + k, 32'h7, clmul_ref(3'b001, 32'h100 + k, 32'h7), 1);
            end
            begin
                for (int k = 0; k < 3; k++)
                    drive_req(1, 3'b001, 32'h200 + k, 32'h7, clmul_ref(3'b001, 32'h200 + k, 32'h7), 1);
            end
        join
        drain();
        check("dual_grant_count", grant_pipe_q.size(), 6);
        for (int i = 0; i < 6 && i < grant_pipe_q.size(); i++) begin
            check("dual_grant_order", grant_pipe_q[i], i % 2);
            if (i > 0) check("dual_grant_gap", grant_gap_q[i], 1);
        end

        // random traffic
        for (int n = 0; n < 30; n++) begin
            unit_lat = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            op = 3'(1 << $urandom_range(0, 2));
            a  = pick_operand();
            b  = pick_operand();
            if (mode == 2) begin
                a2 = pick_operand();
                b2 = pick_operand();
                fork
                    drive_req(0, op, a, b, clmul_ref(op, a, b), 1);
                    drive_req(1, op, a2, b2, clmul_ref(op, a2, b2), 1);
                join
            end else begin
                drive_req(mode, op, a, b, clmul_ref(op, a, b), 1);
            end
        end
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "global timeout");
    end
endmodule
